pong_game_ctrl: RTL and testbench

//   Top-level Pong game-state controller; the driving end of the timer handshake.

---
 rtl/pong_pkg.sv | 6 +
 rtl/pong_bcd_counter.sv | 16 +
 rtl/pong_game_ctrl.sv | 58 +++++
 tb/tb_pong_game_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared state encodings and widths for the pong controller
package pong_pkg;
  typedef enum logic [1:0] {NEWGAME = 2'd0, PLAY = 2'd1, NEWBALL = 2'd2, OVER = 2'd3} state_t;
  localparam int SCORE_W = 8;
  localparam int BALLS_INIT_DEF = 3;
endpackage

// File: rtl/pong_bcd_counter.sv
// pong_bcd_counter: two-digit BCD score counter, wraps 99 -> 00
module pong_bcd_counter
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] bcd
);
  always_ff @(posedge clk)
    if (reset || clr) bcd <= '0;
    else if (inc)
      bcd <= (bcd[3:0] != 4'd9) ? {bcd[7:4], bcd[3:0] + 4'd1} :
             (bcd[7:4] != 4'd9) ? {bcd[7:4] + 4'd1, 4'd0} : 8'h00;
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: pong game-state FSM driving the timer handshake, score and balls left
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int BALLS_INIT = BALLS_INIT_DEF,
  parameter int BALL_W     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               refr_tick,
  input  logic               btn_start,
  input  logic               hit,
  input  logic               miss,
  input  logic               timer_up,
  output logic               timer_start,
  output logic               timer_tick,
  output logic               gra_still,
  output logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [BALL_W-1:0]  balls_left
);
  state_t state, state_n;
  logic btn_q;
  logic btn_press;
  assign btn_press = btn_start & ~btn_q;
  always_comb
    state_n = state == NEWGAME ? (btn_press ? PLAY : NEWGAME) :
              state == PLAY    ? (miss ? (balls_left == '0 ? OVER : NEWBALL) : PLAY) :
              state == NEWBALL ? ((timer_up && btn_press) ? PLAY : NEWBALL) :
                                 (timer_up ? NEWGAME : OVER);
  always_ff @(posedge clk)
    if (reset) begin
      state       <= NEWGAME;
      btn_q       <= 1'b0;
      timer_start <= 1'b0;
      timer_tick  <= 1'b0;
      gra_still   <= 1'b1;
      game_over   <= 1'b0;
      balls_left  <= BALL_W'(BALLS_INIT);
    end else begin
      state       <= state_n;
      btn_q       <= btn_start;
      timer_tick  <= refr_tick;
      timer_start <= state == PLAY && miss;
      gra_still   <= state_n != PLAY;
      game_over   <= state_n == OVER;
      if (state_n == NEWGAME) balls_left <= BALL_W'(BALLS_INIT);
      else if (state == NEWGAME) balls_left <= BALL_W'(BALLS_INIT - 1);
      else if (state == PLAY && state_n == NEWBALL) balls_left <= balls_left - 1'b1;
    end
  pong_bcd_counter u_score (
    .clk  (clk),
    .reset(reset),
    .clr  (state == NEWGAME || (state == OVER && timer_up)),
    .inc  (state == PLAY && hit && !miss),
    .bcd  (score)
  );
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: closed-loop directed bench with a behavioural countdown timer
module tb_pong_game_ctrl;
  logic clk = 1'b0;
  logic reset, refr_tick, btn_start, hit, miss, timer_up;
  logic timer_start, timer_tick, gra_still, game_over;
  logic [7:0] score;
  logic [1:0] balls_left;
  logic [6:0] tmr;
  int checks = 0;
  int errors = 0;
  logic ts_any;
  always #5 clk = ~clk;
  pong_game_ctrl #(.BALLS_INIT(3), .BALL_W(2)) dut (
    .clk(clk), .reset(reset), .refr_tick(refr_tick), .btn_start(btn_start),
    .hit(hit), .miss(miss), .timer_up(timer_up), .timer_start(timer_start),
    .timer_tick(timer_tick), .gra_still(gra_still), .game_over(game_over),
    .score(score), .balls_left(balls_left)
  );
  always @(posedge clk)
    if (reset || timer_start) tmr <= 7'h7f;
    else if (timer_tick && tmr != 7'd0) tmr <= tmr - 7'd1;
  assign timer_up = (tmr == 7'd0);
  initial begin
    refr_tick = 1'b0;
    forever begin
      repeat (19) @(negedge clk);
      refr_tick = 1'b1;
      @(negedge clk);
      refr_tick = 1'b0;
    end
  end
  initial begin
    #5ms;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(negedge clk);
    #1;
  endtask
  task automatic hit_once;
    hit = 1'b1;
    step;
    hit = 1'b0;
    step;
  endtask
  task automatic press;
    btn_start = 1'b1;
    step;
    btn_start = 1'b0;
  endtask
  task automatic wait_up;
    int n = 0;
    while (!timer_up && n < 5000) begin
      step;
      n++;
    end
    chk("timer_up_seen", timer_up, 1);
  endtask
  task automatic chk_reset_outs(input string tag);
    chk({tag, "_still"}, gra_still, 1);
    chk({tag, "_over"}, game_over, 0);
    chk({tag, "_score"}, score, 8'h00);
    chk({tag, "_balls"}, balls_left, 3);
    chk({tag, "_tstart"}, timer_start, 0);
    chk({tag, "_ttick"}, timer_tick, 0);
  endtask
  initial begin
    reset = 1'b1; btn_start = 1'b0; hit = 1'b0; miss = 1'b0;
    step; step;
    chk_reset_outs("rst");
    reset = 1'b0;
    ts_any = 1'b0;
    repeat (100) begin
      step;
      ts_any |= timer_start;
    end
    chk("idle_tstart_never", ts_any, 0);
    chk("idle_still", gra_still, 1);
    chk("idle_score", score, 8'h00);
    chk("idle_balls", balls_left, 3);
    for (int n = 0; n < 40 && !refr_tick; n++) step;
    chk("refr_seen", refr_tick, 1);
    chk("tick_lat0", timer_tick, 0);
    step;
    chk("tick_lat1", timer_tick, 1);
    hit = 1'b1; miss = 1'b1;
    step;
    hit = 1'b0; miss = 1'b0;
    chk("ng_miss_tstart", timer_start, 0);
    chk("ng_hit_score", score, 8'h00);
    chk("ng_balls", balls_left, 3);
    btn_start = 1'b1;
    step;
    chk("play_still", gra_still, 0);
    chk("play_balls", balls_left, 2);
    repeat (5) hit_once;
    chk("score5", score, 8'h05);
    repeat (3) step;
    chk("held_balls", balls_left, 2);
    chk("held_still", gra_still, 0);
    btn_start = 1'b0;
    miss = 1'b1;
    step;
    miss = 1'b0;
    chk("miss1_tstart", timer_start, 1);
    chk("miss1_still", gra_still, 1);
    chk("miss1_balls", balls_left, 1);
    step;
    chk("miss1_tstart_off", timer_start, 0);
    btn_start = 1'b1;
    step;
    chk("nb_early_btn", gra_still, 1);
    wait_up;
    step;
    chk("nb_held_btn", gra_still, 1);
    chk("nb_score", score, 8'h05);
    btn_start = 1'b0;
    step;
    press;
    chk("nb_play", gra_still, 0);
    hit = 1'b1; miss = 1'b1;
    step;
    hit = 1'b0; miss = 1'b0;
    chk("hm_score", score, 8'h05);
    chk("hm_tstart", timer_start, 1);
    chk("hm_balls", balls_left, 0);
    chk("hm_still", gra_still, 1);
    wait_up;
    press;
    chk("nb2_play", gra_still, 0);
    repeat (5) hit_once;
    chk("carry10", score, 8'h10);
    repeat (89) hit_once;
    chk("score99", score, 8'h99);
    hit_once;
    chk("wrap00", score, 8'h00);
    miss = 1'b1;
    step;
    miss = 1'b0;
    chk("over_tstart", timer_start, 1);
    chk("over_flag", game_over, 1);
    chk("over_still", gra_still, 1);
    chk("over_balls", balls_left, 0);
    step;
    chk("over_tstart_off", timer_start, 0);
    press;
    step;
    chk("over_btn_ignored", game_over, 1);
    wait_up;
    step;
    chk("ng2_over", game_over, 0);
    chk("ng2_score", score, 8'h00);
    chk("ng2_balls", balls_left, 3);
    chk("ng2_still", gra_still, 1);
    press;
    chk("g2_play", gra_still, 0);
    hit_once;
    hit_once;
    chk("g2_score", score, 8'h02);
    reset = 1'b1; hit = 1'b1; miss = 1'b1;
    step;
    chk_reset_outs("rst_play");
    reset = 1'b0; hit = 1'b0; miss = 1'b0;
    step;
    chk("rst_play_tstart_after", timer_start, 0);
    chk("rst_play_still_after", gra_still, 1);
    press;
    miss = 1'b1;
    step;
    miss = 1'b0;
    chk("g3_nb_balls", balls_left, 1);
    repeat (10) step;
    reset = 1'b1;
    step;
    chk_reset_outs("rst_nb");
    reset = 1'b0;
    step;
    chk("rst_nb_tstart_after", timer_start, 0);
    chk("rst_nb_balls_after", balls_left, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
